// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single full-adder cell with its carry flop; the whole arithmetic core of the serial unit.
module serial_fa_cell (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic cin_init,
  input  logic a_bit,
  input  logic b_bit,
  input  logic en,
  output logic s,
  output logic c
);

  logic c_next;

  always_comb begin
    s      = a_bit ^ b_bit ^ c;
    c_next = (a_bit & b_bit) | (c & (a_bit ^ b_bit));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c <= 1'b0;
    end else if (load) begin
      c <= cin_init;
    end else if (en) begin
      c <= c_next;
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("serial_addsub: WIDTH must be in 2..64");
  end

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             accept;
  logic             step;
  logic             last;
  logic             s_bit;
  logic             c_bit;
  logic             c_out;

  always_comb begin
    accept = start && (state != RUN);
    step   = (state == RUN);
    last   = step && (cnt == '0);
    c_out  = (op_a[0] & op_b[0]) | (c_bit & (op_a[0] ^ op_b[0]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  serial_fa_cell u_fa (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .cin_init (sub),
    .a_bit    (op_a[0]),
    .b_bit    (op_b[0]),
    .en       (step),
    .s        (s_bit),
    .c        (c_bit)
  );

  // Operand shift registers: B is stored inverted for subtract so the cell only ever adds.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= a;
      op_b <= sub ? ~b : b;
    end else if (step) begin
      op_a <= op_a >> 1;
      op_b <= op_b >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if (step) begin
      sum <= {s_bit, sum[WIDTH-1:1]};
      if (last) begin
        cout <= c_out;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (last) begin
      ovf <= c_bit ^ c_out;
    end
  end
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH 8, 2 and 32; ovf checked when SERIAL_ADDSUB_OVF_EN is set.
module tb_serial_addsub;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q32[$];

  logic        start8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        cout8, busy8, done8;
  logic        start2 = 1'b0, sub2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0, sum2;
  logic        cout2, busy2, done2;
  logic        start32 = 1'b0, sub32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        cout32, busy32, done32;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic        ovf8, ovf2, ovf32;
`endif

  localparam logic [7:0] DA [5] = '{8'h66, 8'h66, 8'h72, 8'hFF, 8'h80};
  localparam logic [7:0] DB [5] = '{8'h72, 8'h72, 8'h66, 8'h01, 8'h01};
  localparam logic       DS [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [7:0] DR [5] = '{8'hD8, 8'hF4, 8'h0C, 8'h00, 8'h7F};
  localparam logic       DC [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic       DO [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_addsub #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .sum(sum2), .cout(cout2), .busy(busy2), .done(done2)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .ovf(ovf2)
`endif
  );

  serial_addsub #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .sum(sum32), .cout(cout32), .busy(busy32), .done(done32)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .ovf(ovf32)
`endif
  );

  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic s);
    logic [64:0] mask, xa, yb, full;
    exp_t e;
    mask   = (65'd1 << w) - 65'd1;
    xa     = {1'b0, x} & mask;
    yb     = s ? (((~{1'b0, y}) & mask) + 65'd1) : ({1'b0, y} & mask);
    full   = xa + yb;
    e.sum  = 64'(full & mask);
    e.cout = full[w];
    e.ovf  = (x[w-1] == (y[w-1] ^ s)) && (e.sum[w-1] != x[w-1]);
    return e;
  endfunction

  // Drivers: called at a negedge, return at the negedge just after the accept edge.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic s, input exp_t e);
    q8.push_back(e);
    a8 = x; b8 = y; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue2(input logic [1:0] x, input logic [1:0] y, input logic s);
    q2.push_back(model(2, 64'(x), 64'(y), s));
    a2 = x; b2 = y; sub2 = s; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] x, input logic [31:0] y, input logic s);
    q32.push_back(model(32, 64'(x), 64'(y), s));
    a32 = x; b32 = y; sub32 = s; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic wait8(input int k0, output int k);
    k = k0;
    while (!done8 && k < 12) begin @(negedge clk); k++; end
  endtask

  task automatic wait2(output int k);
    k = 0;
    while (!done2 && k < 6) begin @(negedge clk); k++; end
  endtask

  task automatic wait32(output int k);
    k = 0;
    while (!done32 && k < 36) begin @(negedge clk); k++; end
  endtask

  task automatic test_reset;
    #2;
    checks += 4;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
    if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done8); end
    if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum8); end
    if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout8); end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++;
    if (ovf8 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf8); end
`endif
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk); @(negedge clk);
    checks += 2;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy8); end
    if (done8 !== 1'b0) begin errors++; $display("FAIL idle_done got %b want 0", done8); end
  endtask

  task automatic test_directed;
    exp_t e;
    int   k;
    for (int i = 0; i < 5; i++) begin
      e.sum = 64'(DR[i]); e.cout = DC[i]; e.ovf = DO[i];
      issue8(DA[i], DB[i], DS[i], e);
      wait8(0, k);
      e = q8.pop_front();
      checks += 3;
      if (k != 8) begin errors++; $display("FAIL dir%0d_latency got %0d want 8", i, k); end
      if (sum8 !== e.sum[7:0]) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, sum8, e.sum[7:0]); end
      if (cout8 !== e.cout) begin errors++; $display("FAIL dir%0d_cout got %b want %b", i, cout8, e.cout); end
`ifdef SERIAL_ADDSUB_OVF_EN
      checks++;
      if (ovf8 !== e.ovf) begin errors++; $display("FAIL dir%0d_ovf got %b want %b", i, ovf8, e.ovf); end
`endif
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int   k;
    issue8(8'h3C, 8'h11, 1'b0, model(8, 64'h3C, 64'h11, 1'b0));
    repeat (3) @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL ign_busy got %b want 1", busy8); end
    wait8(4, k);
    e = q8.pop_front();
    checks += 3;
    if (k != 8) begin errors++; $display("FAIL ign_latency got %0d want 8", k); end
    if (sum8 !== e.sum[7:0]) begin errors++; $display("FAIL ign_sum got %h want %h", sum8, e.sum[7:0]); end
    if (cout8 !== e.cout) begin errors++; $display("FAIL ign_cout got %b want %b", cout8, e.cout); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   k;
    e = model(8, 64'hC3, 64'h5E, 1'b1);
    q8.push_back(e);
    q8.push_back(e);
    a8 = 8'hC3; b8 = 8'h5E; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    checks += 2;
    if (done8 !== 1'b0) begin errors++; $display("FAIL b2b_done0 got %b want 0", done8); end
    if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_busy0 got %b want 1", busy8); end
    wait8(0, k);
    e = q8.pop_front();
    checks += 3;
    if (k != 8) begin errors++; $display("FAIL b2b_lat0 got %0d want 8", k); end
    if (sum8 !== e.sum[7:0]) begin errors++; $display("FAIL b2b_sum0 got %h want %h", sum8, e.sum[7:0]); end
    if (cout8 !== e.cout) begin errors++; $display("FAIL b2b_cout0 got %b want %b", cout8, e.cout); end
    @(negedge clk);
    start8 = 1'b0;
    checks += 2;
    if (done8 !== 1'b0) begin errors++; $display("FAIL b2b_done1 got %b want 0", done8); end
    if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_busy1 got %b want 1", busy8); end
    wait8(0, k);
    e = q8.pop_front();
    checks += 2;
    if (k != 8) begin errors++; $display("FAIL b2b_lat1 got %0d want 8", k); end
    if (sum8 !== e.sum[7:0]) begin errors++; $display("FAIL b2b_sum1 got %h want %h", sum8, e.sum[7:0]); end
  endtask

  task automatic test_reset_mid_run;
    exp_t e;
    int   k;
    issue8(8'h5A, 8'h33, 1'b1, model(8, 64'h5A, 64'h33, 1'b1));
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    e = q8.pop_front();
    checks += 4;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy8); end
    if (done8 !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done8); end
    if (sum8 !== 8'h00) begin errors++; $display("FAIL rst_sum got %h want 00", sum8); end
    if (cout8 !== 1'b0) begin errors++; $display("FAIL rst_cout got %b want 0", cout8); end
`ifdef SERIAL_ADDSUB_OVF_EN
    checks++;
    if (ovf8 !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", ovf8); end
`endif
    q8.push_back(model(8, 64'h9C, 64'h47, 1'b0));
    a8 = 8'h9C; b8 = 8'h47; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    wait8(0, k);
    e = q8.pop_front();
    checks += 3;
    if (k != 8) begin errors++; $display("FAIL post_rst_latency got %0d want 8", k); end
    if (sum8 !== e.sum[7:0]) begin errors++; $display("FAIL post_rst_sum got %h want %h", sum8, e.sum[7:0]); end
    if (cout8 !== e.cout) begin errors++; $display("FAIL post_rst_cout got %b want %b", cout8, e.cout); end
  endtask

  task automatic test_random_w2;
    exp_t e;
    int   k;
    for (int i = 0; i < 1000; i++) begin
      issue2(2'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
      wait2(k);
      e = q2.pop_front();
      checks += 3;
      if (k != 2) begin errors++; $display("FAIL w2_lat[%0d] got %0d want 2", i, k); end
      if (sum2 !== e.sum[1:0]) begin errors++; $display("FAIL w2_sum[%0d] got %h want %h", i, sum2, e.sum[1:0]); end
      if (cout2 !== e.cout) begin errors++; $display("FAIL w2_cout[%0d] got %b want %b", i, cout2, e.cout); end
`ifdef SERIAL_ADDSUB_OVF_EN
      checks++;
      if (ovf2 !== e.ovf) begin errors++; $display("FAIL w2_ovf[%0d] got %b want %b", i, ovf2, e.ovf); end
`endif
    end
  endtask

  task automatic test_random_w32;
    exp_t e;
    int   k;
    for (int i = 0; i < 1000; i++) begin
      issue32($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait32(k);
      e = q32.pop_front();
      checks += 3;
      if (k != 32) begin errors++; $display("FAIL w32_lat[%0d] got %0d want 32", i, k); end
      if (sum32 !== e.sum[31:0]) begin errors++; $display("FAIL w32_sum[%0d] got %h want %h", i, sum32, e.sum[31:0]); end
      if (cout32 !== e.cout) begin errors++; $display("FAIL w32_cout[%0d] got %b want %b", i, cout32, e.cout); end
`ifdef SERIAL_ADDSUB_OVF_EN
      checks++;
      if (ovf32 !== e.ovf) begin errors++; $display("FAIL w32_ovf[%0d] got %b want %b", i, ovf32, e.ovf); end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_random_w2;
    test_random_w32;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
